// File: rtl/dm_trace_pkg.sv
// Shared types for the traced data memory: trace entry layout, entry kind,
// sweep FSM states and the byte-lane merge helper.
package dm_trace_pkg;

    typedef enum logic {
        TK_MEM = 1'b0,
        TK_GRF = 1'b1
    } trace_kind_t;

    typedef struct packed {
        trace_kind_t kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dm_state_t;

    // Replace each enabled byte lane of old_w with the matching lane of new_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Two-push / one-pop FIFO of trace entries. push0 is the older event and wins
// the last free slot; anything that does not fit is dropped and latches
// overflow. The head comes straight from storage, so no input reaches it
// combinationally.
module trace_fifo
    import dm_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push0,
    input  trace_entry_t           entry0,
    input  logic                   push1,
    input  trace_entry_t           entry1,
    input  logic                   pop,
    output logic                   valid,
    output trace_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int PW = $clog2(DEPTH);

    trace_entry_t  slots [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW+1:0] free;
    logic [1:0]    n_push;
    logic          pop_ok, acc0, acc1, drop;
    trace_entry_t  first_e;

    assign valid   = (count != '0);
    assign pop_ok  = pop && valid;
    // A slot freed by this cycle's pop can be refilled on the same edge.
    assign free    = (PW+2)'(DEPTH) - {1'b0, count} + {{(PW+1){1'b0}}, pop_ok};
    assign acc0    = push0 && (free != '0);
    assign acc1    = push1 && (push0 ? (free >= (PW+2)'(2)) : (free != '0));
    assign drop    = (push0 && !acc0) || (push1 && !acc1);
    assign first_e = acc0 ? entry0 : entry1;
    assign n_push  = {1'b0, acc0} + {1'b0, acc1};
    assign head    = valid ? slots[rd_ptr] : '0;

    // Storage write: accepted entries land in consecutive slots, oldest first.
    always_ff @(posedge clk) begin
        if (acc0 || acc1)
            slots[wr_ptr] <= first_e;
        if (acc0 && acc1)
            slots[wr_ptr + 1'b1] <= entry1;
    end

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            wr_ptr <= wr_ptr + PW'(n_push);
            count  <= count + (PW+1)'(n_push) - (PW+1)'(pop_ok);
            if (drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/dm_trace_mem.sv
// Word-organised data memory for the pipelined core. After reset a sweep
// zeroes every word; afterwards byte-enabled stores are merged into memory
// and every in-range store and non-zero GRF write is queued as a trace entry.
module dm_trace_mem
    import dm_trace_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          RD_LAT      = 0,
    parameter int          TRACE_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  m_data_addr,
    input  logic [31:0]                  m_data_wdata,
    input  logic [3:0]                   m_data_byteen,
    input  logic [31:0]                  m_inst_addr,
    output logic [31:0]                  m_data_rdata,
    input  logic                         w_grf_we,
    input  logic [4:0]                   w_grf_addr,
    input  logic [31:0]                  w_grf_wdata,
    input  logic [31:0]                  w_inst_addr,
    output logic                         busy,
    output logic                         err_oob,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic                         trace_kind,
    output logic [31:0]                  trace_pc,
    output logic [31:0]                  trace_addr,
    output logic [31:0]                  trace_data,
    output logic [$clog2(TRACE_DEPTH):0] trace_count,
    output logic                         trace_overflow
);
    localparam int WORDS = 2 ** ADDR_W;

    logic [31:0]       mem [WORDS];
    dm_state_t         state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [31:0]       fixed_addr, offset, rd_word, merged;
    logic [ADDR_W-1:0] idx;
    logic              run, in_range, store, wr_en, grf_ev, unused_bits;
    trace_entry_t      grf_e, mem_e, head;

    assign run        = (state == ST_RUN);
    assign busy       = !run;
    assign fixed_addr = {m_data_addr[31:2], 2'b00};
    assign offset     = fixed_addr - BASE_ADDR;
    // In range: no underflow below the base and the word index fits the array.
    assign in_range   = (fixed_addr >= BASE_ADDR) && ((offset >> (ADDR_W + 2)) == 32'd0);
    assign idx        = offset[ADDR_W+1:2];
    assign rd_word    = (run && in_range) ? mem[idx] : 32'd0;
    assign merged     = merge_bytes(mem[idx], m_data_wdata, m_data_byteen);
    assign store      = run && (m_data_byteen != 4'd0);
    assign wr_en      = store && in_range;
    assign err_oob    = store && !in_range;
    assign grf_ev     = run && w_grf_we && (w_grf_addr != 5'd0);
    assign unused_bits = ^m_data_addr[1:0];

    // Sweep FSM: walk every word once after reset, then hand over to the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == ADDR_W'(WORDS - 1))
                state <= ST_RUN;
        end
    end

    // Memory array: sweep zeroes during CLEAR, merged stores during RUN.
    always_ff @(posedge clk) begin
        if (!run)
            mem[sweep_cnt] <= 32'd0;
        else if (wr_en)
            mem[idx] <= merged;
    end

    generate
        if (RD_LAT == 0) begin : g_rd_comb
            assign m_data_rdata = rd_word;
        end else begin : g_rd_reg
            logic [31:0] rd_q;
            // Registered read port; captures the pre-write word (read-first).
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    rd_q <= 32'd0;
                else
                    rd_q <= rd_word;
            end
            assign m_data_rdata = rd_q;
        end
    endgenerate

    assign grf_e = '{kind: TK_GRF, pc: w_inst_addr, addr: {27'd0, w_grf_addr}, data: w_grf_wdata};
    assign mem_e = '{kind: TK_MEM, pc: m_inst_addr, addr: fixed_addr, data: merged};

    // The W-stage GRF write is older, so it takes the priority push port.
    trace_fifo #(.DEPTH(TRACE_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push0    (grf_ev),
        .entry0   (grf_e),
        .push1    (wr_en),
        .entry1   (mem_e),
        .pop      (trace_ready),
        .valid    (trace_valid),
        .head     (head),
        .count    (trace_count),
        .overflow (trace_overflow)
    );

    assign trace_kind = head.kind;
    assign trace_pc   = head.pc;
    assign trace_addr = head.addr;
    assign trace_data = head.data;

endmodule

// File: tb/tb_dm_trace_mem.sv
// Bench for dm_trace_mem: directed scenarios followed by random traffic, all
// checked each cycle against a queue/array reference model. Two instances
// share stimulus, one with combinational and one with registered reads.
module tb_dm_trace_mem;
    import dm_trace_pkg::*;

    localparam int     AW    = 4;
    localparam int     NW    = 2 ** AW;
    localparam int     DEPTH = 4;
    localparam int     CW    = $clog2(DEPTH) + 1;
    localparam longint BASE  = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   m_data_addr, m_data_wdata, m_inst_addr, w_grf_wdata, w_inst_addr;
    logic [3:0]    m_data_byteen;
    logic          w_grf_we, trace_ready;
    logic [4:0]    w_grf_addr;

    logic [31:0]   rdata0, rdata1, tpc0, tpc1, taddr0, taddr1, tdata0, tdata1;
    logic          busy0, busy1, oob0, oob1, tv0, tv1, tk0, tk1, ovf0, ovf1;
    logic [CW-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    dm_trace_mem #(.ADDR_W(AW), .BASE_ADDR(32'h0), .RD_LAT(0), .TRACE_DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .m_data_rdata(rdata0),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
        .w_inst_addr(w_inst_addr), .busy(busy0), .err_oob(oob0), .trace_valid(tv0),
        .trace_ready(trace_ready), .trace_kind(tk0), .trace_pc(tpc0), .trace_addr(taddr0),
        .trace_data(tdata0), .trace_count(cnt0), .trace_overflow(ovf0));

    dm_trace_mem #(.ADDR_W(AW), .BASE_ADDR(32'h0), .RD_LAT(1), .TRACE_DEPTH(DEPTH)) u_dut_l1 (
        .clk(clk), .reset(reset), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .m_data_rdata(rdata1),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
        .w_inst_addr(w_inst_addr), .busy(busy1), .err_oob(oob1), .trace_valid(tv1),
        .trace_ready(trace_ready), .trace_kind(tk1), .trace_pc(tpc1), .trace_addr(taddr1),
        .trace_data(tdata1), .trace_count(cnt1), .trace_overflow(ovf1));

    // Reference model state
    logic [31:0]  mmem [NW];
    trace_entry_t q[$];
    bit           movf;
    int           clr_left;
    logic [31:0]  exp_rd1;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a, output int i);
        longint off;
        off = longint'(a) - longint'(a % 4) - BASE;
        i = int'(off / 4);
        return (off >= 0) && (off < 4 * NW);
    endfunction

    task automatic set_idle();
        m_data_addr = 32'h0; m_data_wdata = 32'h0; m_data_byteen = 4'h0; m_inst_addr = 32'h0;
        w_grf_we = 1'b0; w_grf_addr = 5'd0; w_grf_wdata = 32'h0; w_inst_addr = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_idle();
        #1;
        chk("rst_busy", busy0, 1);      chk("rst_oob", oob0, 0);
        chk("rst_tvalid", tv0, 0);      chk("rst_count", cnt0, 0);
        chk("rst_ovf", ovf0, 0);        chk("rst_rdata", rdata0, 0);
        chk("rst_rdata_l1", rdata1, 0); chk("rst_tdata", tdata0, 0);
        chk("rst_tpc", tpc0, 0);        chk("rst_taddr", taddr0, 0);
        chk("rst_count_l1", cnt1, 0);   chk("rst_ovf_l1", ovf1, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        foreach (mmem[k]) mmem[k] = 32'h0;
        q.delete();
        movf = 1'b0;
        clr_left = NW;
        exp_rd1 = 32'h0;
    endtask

    // Check all outputs against the model for the current inputs, then
    // advance the model by one clock edge and step to the next negedge.
    task automatic cycle();
        bit run, inr, mem_ev, grf_ev, popd;
        int i, free;
        logic [31:0] rd, merged;
        #1;
        run = (clr_left == 0);
        inr = in_rng(m_data_addr, i);
        rd  = (run && inr) ? mmem[i] : 32'h0;
        chk("busy", busy0, !run);          chk("busy_l1", busy1, !run);
        chk("rdata", rdata0, rd);          chk("rdata_l1", rdata1, exp_rd1);
        chk("err_oob", oob0, run && m_data_byteen != 0 && !inr);
        chk("err_oob_l1", oob1, run && m_data_byteen != 0 && !inr);
        chk("tvalid", tv0, q.size() != 0); chk("tvalid_l1", tv1, q.size() != 0);
        chk("tcount", cnt0, q.size());     chk("tcount_l1", cnt1, q.size());
        chk("tovf", ovf0, movf);           chk("tovf_l1", ovf1, movf);
        if (q.size() != 0) begin
            chk("tkind", tk0, q[0].kind);  chk("tpc", tpc0, q[0].pc);
            chk("taddr", taddr0, q[0].addr); chk("tdata", tdata0, q[0].data);
            chk("tpc_l1", tpc1, q[0].pc);  chk("tdata_l1", tdata1, q[0].data);
        end
        exp_rd1 = rd;
        popd = (q.size() != 0) && trace_ready;
        free = DEPTH - q.size() + (popd ? 1 : 0);
        if (popd) void'(q.pop_front());
        grf_ev = run && w_grf_we && (w_grf_addr != 0);
        mem_ev = run && (m_data_byteen != 0) && inr;
        merged = rd;
        for (int b = 0; b < 4; b++)
            if (m_data_byteen[b]) merged[8*b +: 8] = m_data_wdata[8*b +: 8];
        if (grf_ev) begin
            if (free > 0) begin
                q.push_back('{kind: TK_GRF, pc: w_inst_addr, addr: {27'd0, w_grf_addr}, data: w_grf_wdata});
                free--;
            end else movf = 1'b1;
        end
        if (mem_ev) begin
            mmem[i] = merged;
            if (free > 0)
                q.push_back('{kind: TK_MEM, pc: m_inst_addr, addr: m_data_addr & ~32'd3, data: merged});
            else movf = 1'b1;
        end
        if (!run) clr_left--;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] pc);
        m_data_addr = a; m_data_wdata = d; m_data_byteen = be; m_inst_addr = pc;
    endtask

    task automatic grf(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
        w_grf_we = 1'b1; w_grf_addr = r; w_grf_wdata = d; w_inst_addr = pc;
    endtask

    initial begin
        trace_ready = 1'b0;
        do_reset();

        // Sweep: a store in the last CLEAR cycle must be ignored.
        repeat (NW - 1) cycle();
        store(32'h8, 32'hFFFF_FFFF, 4'hF, 32'h50);
        cycle();
        set_idle();
        m_data_addr = 32'h8;
        #1;
        chk("clr_store_word", rdata0, 32'h0);
        chk("clr_store_count", cnt0, 0);
        chk("busy_done", busy0, 0);
        cycle();

        // Byte-lane merge
        store(32'h8, 32'h1122_3344, 4'b0101, 32'h100);
        cycle();
        chk("merge_rd", rdata0, 32'h0022_0044);
        chk("merge_tpc", tpc0, 32'h100);
        chk("merge_taddr", taddr0, 32'h8);
        chk("merge_tdata", tdata0, 32'h0022_0044);
        set_idle(); trace_ready = 1'b1;
        cycle();
        trace_ready = 1'b0;

        // Same-cycle GRF and memory events: GRF first
        grf(5'd5, 32'hDEAD, 32'h3000);
        store(32'hC, 32'h0BAD_F00D, 4'hF, 32'h3004);
        cycle();
        chk("dual_count", cnt0, 2);
        chk("dual_first_kind", tk0, 1);
        chk("dual_first_pc", tpc0, 32'h3000);
        chk("dual_first_data", tdata0, 32'hDEAD);
        set_idle(); trace_ready = 1'b1;
        cycle();
        chk("dual_second_kind", tk0, 0);
        chk("dual_second_pc", tpc0, 32'h3004);
        cycle();
        grf(5'd0, 32'h1234, 32'h3008);
        cycle();
        chk("grf0_count", cnt0, 0);
        set_idle(); trace_ready = 1'b0;

        // Out-of-range stores
        store(32'hFFFF_FFFC, 32'h5555_5555, 4'hF, 32'h400);
        #1 chk("oob_low", oob0, 1);
        cycle();
        store(4 * NW, 32'h6666_6666, 4'hF, 32'h404);
        #1 chk("oob_high", oob0, 1);
        cycle();
        set_idle();
        #1 chk("oob_idle", oob0, 0);
        chk("oob_count", cnt0, 0);
        cycle();

        // Overflow: 3 singles fill to 3, then one dual keeps only the GRF
        store(32'h0, 32'hA0, 4'hF, 32'h200); cycle(); set_idle();
        grf(5'd1, 32'hA1, 32'h204);          cycle(); set_idle();
        store(32'h4, 32'hA2, 4'hF, 32'h208); cycle(); set_idle();
        grf(5'd2, 32'hA3, 32'h20C);
        store(32'h14, 32'hA4, 4'hF, 32'h210);
        cycle();
        set_idle();
        chk("ovf_count", cnt0, 4);
        chk("ovf_flag", ovf0, 1);
        trace_ready = 1'b1;
        repeat (3) cycle();
        chk("ovf_last_pc", tpc0, 32'h20C);
        chk("ovf_last_kind", tk0, 1);
        cycle();
        chk("ovf_drained", cnt0, 0);
        chk("ovf_sticky", ovf0, 1);
        trace_ready = 1'b0;

        // Registered read: read-first, new value one cycle later
        store(32'h10, 32'hA5A5_A5A5, 4'hF, 32'h500);
        cycle();
        chk("l1_old", rdata1, 32'h0);
        set_idle();
        m_data_addr = 32'h10;
        cycle();
        chk("l1_new", rdata1, 32'hA5A5_A5A5);

        // Random traffic with one mid-run reset
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            set_idle();
            trace_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) != 0) begin
                store(($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC - $urandom_range(0, 15)
                                                  : $urandom_range(0, 4 * NW + 15),
                      $urandom, 4'($urandom_range(0, 15)), $urandom);
            end else begin
                m_data_addr = $urandom_range(0, 4 * NW + 3);
            end
            if ($urandom_range(0, 1) != 0)
                grf(5'($urandom_range(0, 31)), $urandom, $urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_trace_mem.md
# dm_trace_mem

Parametrised, synthesizable data memory with a built-in commit-trace buffer, sitting between the pipelined `mips` core's M/W-stage ports and the bench or SoC bus. It merges byte-enabled stores into word memory, clears itself after reset with a sweep state machine, and queues every memory write and non-zero GRF write into a 2-push/1-pop trace FIFO. The FIFO is drained over a valid/ready handshake, replacing per-cycle `$display` logging with a checkable stream.

## Interface
- `ADDR_W`, 12: word-address bits; depth = 2^ADDR_W words.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `RD_LAT`, 0: read latency in cycles, 0 (combinational) or 1 (registered).
- `TRACE_DEPTH`, 16: trace FIFO entries; power of two, ≥2.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m_data_addr`  in  32  byte address (M stage).
- `m_data_wdata`  in  32  store data, already lane-aligned.
- `m_data_byteen`  in  4  byte write enables; 0 = no write.
- `m_inst_addr`  in  32  PC of the M-stage instruction.
- `m_data_rdata`  out  32  read word at `m_data_addr & ~3`.
- `w_grf_we`  in  1  GRF write enable (W stage).
- `w_grf_addr`  in  5  GRF destination.
- `w_grf_wdata`  in  32  GRF write data.
- `w_inst_addr`  in  32  PC of the W-stage instruction.
- `busy`  out  1  clear sweep in progress.
- `err_oob`  out  1  one-cycle pulse: write outside memory range.
- `trace_valid`  out  1  head entry available.
- `trace_ready`  in  1  consumer accepts head entry.
- `trace_kind`  out  1  0 = memory write, 1 = GRF write.
- `trace_pc`  out  32  instruction address.
- `trace_addr`  out  32  aligned byte address, or GRF index zero-extended.
- `trace_data`  out  32  merged memory word, or GRF data.
- `trace_count`  out  $clog2(TRACE_DEPTH)+1  current occupancy.
- `trace_overflow`  out  1  sticky: an event was dropped.

## Operation
- Address: `fixed_addr = m_data_addr & ~3`; `idx = (fixed_addr - BASE_ADDR) >> 2`. The address is in range iff the subtraction does not underflow and `idx < 2^ADDR_W`.
- FSM `CLEAR` → `RUN`:
  - Reset enters `CLEAR` with sweep counter 0.
  - Each `CLEAR` cycle writes 0 to word `counter`, then increments the counter.
  - After writing word 2^ADDR_W−1, the FSM moves to `RUN`.
  - `busy` = 1 in `CLEAR`.
- During `CLEAR`:
  - Reads return 0.
  - Core writes are ignored; they produce no trace entry and no `err_oob`.
- `RUN` store behaviour, when `|byteen`:
  - In range: each enabled byte lane replaces the stored byte; the merged word is written.
  - Out of range: no write, no trace entry, `err_oob` = 1 for that cycle.
- Reads are read-first: a same-cycle write to the same word is not visible until the next cycle.
- Trace events per cycle, both only in `RUN`:
  - GRF event: `w_grf_we && w_grf_addr != 0`.
  - Memory event: an in-range store.
- Ordering: a GRF event is enqueued ahead of a same-cycle memory event, because the W instruction is older.
- Free space this cycle = `TRACE_DEPTH − count + (trace_valid && trace_ready)`.
  - Free ≥ 2: both events accepted.
  - Free = 1: the older event is accepted and the other is dropped.
  - Free = 0: all events this cycle are dropped.
  - Any drop sets `trace_overflow` until reset.
- A pop happens when `trace_valid && trace_ready`; the next entry is presented the following cycle.

## Timing
- Reset values:
  - `busy` = 1, `err_oob` = 0, `trace_valid` = 0, `trace_count` = 0, `trace_overflow` = 0.
  - `m_data_rdata` = 0 (registered copy when `RD_LAT` = 1); all `trace_*` data outputs = 0.
- `busy` falls exactly 2^ADDR_W cycles after reset deasserts.
- `RD_LAT` = 0: `m_data_rdata` follows the address combinationally. `RD_LAT` = 1: data appears one edge after the address is presented.
- Memory write commits on the edge where the store is sampled.
- Trace entry latency: an event sampled at edge N gives `trace_valid` = 1 after edge N.
  - The entry is a registered FIFO head, with no combinational path from inputs.
  - With two events at edge N, the second entry is at the head one cycle after the first is popped.
- `trace_count` updates each edge by (pushes − pop).
- Reset asserted mid-sweep or mid-run:
  - Flushes the FIFO immediately (asynchronously) and restarts `CLEAR` at word 0.
  - Memory contents are only guaranteed zero after the sweep completes.

## Structure
- Package `dm_trace_pkg` holds:
  - The `trace_kind_t` enum (`TK_MEM`, `TK_GRF`).
  - The `trace_entry_t` struct (kind, pc, addr, data).
  - The FSM state enum.
- Sub-module `trace_fifo`: generic 2-push, 1-pop FIFO of `trace_entry_t`.
  - Ports: push0/push1 with entries, pop, head, count, overflow.
  - Push0 has priority.
- The top level holds the memory array, sweep FSM, byte merge and event generation.

## Test plan
- Reset low for 2 cycles, `ADDR_W` = 4:
  - `busy` is high for exactly 16 cycles after release.
  - A store issued during `CLEAR` leaves the word at 0 and produces no trace entry.
- In `RUN`, store `wdata`=32'h11223344, `byteen`=4'b0101, to addr 0x8 (word previously 0):
  - Word 2 reads 32'h00220044.
  - Trace entry = {0, pc, 0x8, 32'h00220044}.
- Same cycle, GRF write $5 ← 32'hDEAD with `w_inst_addr`=0x3000, plus an in-range store at `m_inst_addr`=0x3004:
  - Two entries pop in order: GRF entry (pc 0x3000), then memory entry (pc 0x3004).
  - A GRF write to $0 produces no entry.
- Store to `BASE_ADDR − 4`, then to 4·2^ADDR_W:
  - `err_oob` pulses once per store.
  - Memory is unchanged; `trace_count` is unchanged.
- `TRACE_DEPTH` = 4, `trace_ready` = 0:
  - Issue 3 single events, then one dual-event cycle.
  - The GRF entry is kept, the memory entry is dropped, `trace_overflow` = 1 and stays 1 after draining.
- `RD_LAT` = 1, write word 0x10 with 32'hA5A5A5A5 and read 0x10 in the same cycle:
  - The next cycle returns the old value.
  - The read after that returns 32'hA5A5A5A5.
